// File: rtl/memory_cycle.sv
// RV32I memory stage plus the M/W pipeline register: byte/half/word loads and
// stores against an internal word-organised data memory, extended and registered.
module memory_cycle #(
   parameter int MEM_WORDS = 1024,
   parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  RdM,
   input  logic [31:0] PCPlus4M,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [4:0]  RdW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] PCPlus4W
);

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   logic [31:0]       mem [MEM_WORDS];
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_off;
   logic [3:0]        byte_en;
   logic [31:0]       store_data;
   logic [31:0]       raw_word;
   logic [7:0]        load_byte;
   logic [15:0]       load_half;
   logic [31:0]       load_ext;

   // Upper address bits are dropped, so accesses wrap modulo MEM_WORDS*4.
   assign word_idx = ALUResultM[ADDR_W+1:2];
   assign byte_off = ALUResultM[1:0];

   // Store data is replicated across lanes so each enabled lane picks its own slice.
   always_comb begin
      byte_en    = 4'b0000;
      store_data = WriteDataM;
      case (funct3M)
         F3_B: begin
            byte_en    = 4'b0001 << byte_off;
            store_data = {4{WriteDataM[7:0]}};
         end
         F3_H: begin
            byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
            store_data = {2{WriteDataM[15:0]}};
         end
         F3_W:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   assign raw_word  = mem[word_idx];
   assign load_half = byte_off[1] ? raw_word[31:16] : raw_word[15:0];

   always_comb begin
      load_byte = raw_word[7:0];
      case (byte_off)
         2'd0: load_byte = raw_word[7:0];
         2'd1: load_byte = raw_word[15:8];
         2'd2: load_byte = raw_word[23:16];
         2'd3: load_byte = raw_word[31:24];
         default: load_byte = raw_word[7:0];
      endcase
   end

   always_comb begin
      load_ext = raw_word;
      case (funct3M)
         F3_B:    load_ext = {{24{load_byte[7]}}, load_byte};
         F3_BU:   load_ext = {24'h0, load_byte};
         F3_H:    load_ext = {{16{load_half[15]}}, load_half};
         F3_HU:   load_ext = {16'h0, load_half};
         default: load_ext = raw_word;
      endcase
   end

   // NOTE: the data memory has no reset; contents are undefined until written and survive rst.
   always_ff @(posedge clk) begin
      if (!rst && MemWriteM) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (byte_en[lane]) mem[word_idx][lane*8 +: 8] <= store_data[lane*8 +: 8];
         end
      end
   end

   // NOTE: non-blocking updates make the same-edge read see pre-store memory contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         RdW        <= 5'd0;
         ALUResultW <= 32'h0;
         ReadDataW  <= 32'h0;
         PCPlus4W   <= 32'h0;
      end else begin
         RegWriteW  <= RegWriteM;
         ResultSrcW <= ResultSrcM;
         RdW        <= RdM;
         ALUResultW <= ALUResultM;
         ReadDataW  <= load_ext;
         PCPlus4W   <= PCPlus4M;
      end
   end

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: table of M-stage vectors with expected
// W-stage results, queued at drive time and compared one edge later.
module tb_memory_cycle;

   logic        clk;
   logic        rst;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [4:0]  RdM;
   logic [31:0] PCPlus4M;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [4:0]  RdW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [31:0] PCPlus4W;

   memory_cycle #(.MEM_WORDS(1024)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
      .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .RdM(RdM), .PCPlus4M(PCPlus4M),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic        rw;
      logic [1:0]  rs;
      logic        mw;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      string       name;
      logic        rw;
      logic [1:0]  rs;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic        chk_rd;
      logic [31:0] rdata;
      logic [31:0] pc4;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic r, input logic rw,
                               input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] rd, input logic [31:0] pc4,
                               input logic chk, input logic [31:0] exp_rd);
      vec_t v;
      v.name = name; v.rst = r; v.rw = rw; v.rs = rs; v.mw = mw; v.f3 = f3;
      v.alu = alu; v.wd = wd; v.rd = rd; v.pc4 = pc4; v.chk_rd = chk; v.exp_rd = exp_rd;
      return v;
   endfunction

   function automatic vec_t store(input string name, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
      return mk(name, 1'b0, 1'b0, 2'b00, 1'b1, f3, addr, wd, 5'd0, 32'h200, 1'b0, 32'h0);
   endfunction

   function automatic vec_t load(input string name, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] exp_rd);
      return mk(name, 1'b0, 1'b1, 2'b01, 1'b0, f3, addr, 32'h0, 5'd5, 32'h300, 1'b1, exp_rd);
   endfunction

   function automatic vec_t rnd(input string name, input logic r);
      return mk(name, r, 1'($urandom), 2'($urandom), 1'($urandom), 3'($urandom),
                $urandom, $urandom, 5'($urandom), $urandom, 1'b0, 32'h0);
   endfunction

   // Drive on the falling edge and queue what the W stage must show after the next rising edge.
   task automatic drive(input vec_t v);
      exp_t e;
      @(negedge clk);
      rst = v.rst; RegWriteM = v.rw; ResultSrcM = v.rs; MemWriteM = v.mw;
      funct3M = v.f3; ALUResultM = v.alu; WriteDataM = v.wd; RdM = v.rd; PCPlus4M = v.pc4;
      e.name = v.name;
      if (v.rst) begin
         e.rw = 1'b0; e.rs = 2'b00; e.rd = 5'd0; e.alu = 32'h0; e.pc4 = 32'h0;
         e.chk_rd = 1'b1; e.rdata = 32'h0;
      end else begin
         e.rw = v.rw; e.rs = v.rs; e.rd = v.rd; e.alu = v.alu; e.pc4 = v.pc4;
         e.chk_rd = v.chk_rd; e.rdata = v.exp_rd;
      end
      sb_q.push_back(e);
   endtask

   task automatic sample();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      check({e.name, ".RegWriteW"},  {31'h0, RegWriteW},  {31'h0, e.rw});
      check({e.name, ".ResultSrcW"}, {30'h0, ResultSrcW}, {30'h0, e.rs});
      check({e.name, ".RdW"},        {27'h0, RdW},        {27'h0, e.rd});
      check({e.name, ".ALUResultW"}, ALUResultW, e.alu);
      check({e.name, ".PCPlus4W"},   PCPlus4W,   e.pc4);
      if (e.chk_rd) check({e.name, ".ReadDataW"}, ReadDataW, e.rdata);
   endtask

   task automatic apply(input vec_t v);
      drive(v);
      sample();
   endtask

   initial begin
      rst = 1'b1; RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; funct3M = 3'b000;
      ALUResultM = 32'h0; WriteDataM = 32'h0; RdM = 5'd0; PCPlus4M = 32'h0;

      vecs.push_back(rnd("reset0", 1'b1));
      vecs.push_back(rnd("reset1", 1'b1));
      vecs.push_back(mk("release", 1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 32'h1234_5678,
                        32'h0, 5'd3, 32'h0000_0100, 1'b0, 32'h0));
      vecs.push_back(store("sw_10", 3'b010, 32'h10, 32'hDEAD_BEEF));
      vecs.push_back(load("lw_10", 3'b010, 32'h10, 32'hDEAD_BEEF));
      vecs.push_back(store("sb_11", 3'b000, 32'h11, 32'h1234_5680));
      vecs.push_back(load("lw_10_after_sb", 3'b010, 32'h10, 32'hDEAD_80EF));
      vecs.push_back(load("lb_11", 3'b000, 32'h11, 32'hFFFF_FF80));
      vecs.push_back(load("lbu_11", 3'b100, 32'h11, 32'h0000_0080));
      vecs.push_back(store("sh_12", 3'b001, 32'h12, 32'hABCD_8001));
      vecs.push_back(load("lh_12", 3'b001, 32'h12, 32'hFFFF_8001));
      vecs.push_back(load("lhu_12", 3'b101, 32'h12, 32'h0000_8001));
      vecs.push_back(load("lw_10_after_sh", 3'b010, 32'h10, 32'h8001_80EF));
      vecs.push_back(load("lb_13", 3'b000, 32'h13, 32'hFFFF_FF80));
      vecs.push_back(load("lbu_10", 3'b100, 32'h10, 32'h0000_00EF));
      vecs.push_back(load("lh_10", 3'b001, 32'h10, 32'hFFFF_80EF));
      vecs.push_back(load("lhu_11_odd", 3'b101, 32'h11, 32'h0000_80EF));
      vecs.push_back(store("sw_1004_wrap", 3'b010, 32'h0000_1004, 32'hA5A5_A5A5));
      vecs.push_back(load("lw_04_wrap", 3'b010, 32'h0000_0004, 32'hA5A5_A5A5));
      vecs.push_back(mk("jal", 1'b0, 1'b1, 2'b10, 1'b0, 3'b000, 32'h0000_0200,
                        32'h0, 5'd1, 32'h0000_0104, 1'b0, 32'h0));
      vecs.push_back(store("sw_30", 3'b010, 32'h30, 32'h5A5A_5A5A));
      vecs.push_back(store("s011_30", 3'b011, 32'h30, 32'hFFFF_FFFF));
      vecs.push_back(store("s110_31", 3'b110, 32'h31, 32'h0000_0000));
      vecs.push_back(load("lw_30_after_bad", 3'b010, 32'h30, 32'h5A5A_5A5A));
      vecs.push_back(load("l111_31_raw", 3'b111, 32'h31, 32'h5A5A_5A5A));

      foreach (vecs[i]) apply(vecs[i]);

      // Same-cycle store and read of one word: the store cycle itself reads the old word.
      apply(store("sw_20_init", 3'b010, 32'h20, 32'h1111_1111));
      apply(mk("sw_20_rmw", 1'b0, 1'b0, 2'b01, 1'b1, 3'b010, 32'h20, 32'h2222_2222,
               5'd0, 32'h0000_0204, 1'b1, 32'h1111_1111));
      apply(load("lw_20_new", 3'b010, 32'h20, 32'h2222_2222));

      // A store presented during reset is dropped; earlier contents survive reset.
      apply(mk("sw_20_in_rst", 1'b1, 1'b1, 2'b01, 1'b1, 3'b010, 32'h20, 32'h3333_3333,
               5'd7, 32'h0000_0208, 1'b0, 32'h0));
      apply(load("lw_20_post_rst", 3'b010, 32'h20, 32'h2222_2222));
      apply(load("lw_10_post_rst", 3'b010, 32'h10, 32'h8001_80EF));

      // Back-to-back issue with the scoreboard two deep: load in flight when reset hits.
      drive(load("lw_04_pre_rst", 3'b010, 32'h4, 32'hA5A5_A5A5));
      fork
         sample();
         drive(rnd("rst_midstream", 1'b1));
      join
      sample();

      if (sb_q.size() != 0) check("scoreboard_leftover", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory (M) stage of the RV32I 5-stage pipeline, including the M/W pipeline register. It performs loads and stores against an internal word-organised data memory, with byte, halfword and word access selected by funct3. It then registers the extended load data and the pass-through control and data into the write-back stage. The registered ALU result, read data, PC+4, ResultSrc, RegWrite and Rd outputs connect directly to the write-back result mux and the register file.

## Interface
Parameters:
- `MEM_WORDS`, 1024: data memory depth in 32-bit words; power of two, ≥ 4.
- `ADDR_W`, $clog2(MEM_WORDS): word-index width, derived.

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RegWriteM`  in  1  register-file write enable for this instruction.
- `ResultSrcM`  in  2  write-back select: 00 ALU, 01 load data, 10 PC+4.
- `MemWriteM`  in  1  store enable.
- `funct3M`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ALUResultM`  in  32  effective address, or ALU result for non-memory instructions.
- `WriteDataM`  in  32  store data (rs2 after forwarding).
- `RdM`  in  5  destination register.
- `PCPlus4M`  in  32  PC+4.
- `RegWriteW`  out  1  registered `RegWriteM`.
- `ResultSrcW`  out  2  registered `ResultSrcM`.
- `RdW`  out  5  registered `RdM`.
- `ALUResultW`  out  32  registered `ALUResultM`.
- `ReadDataW`  out  32  registered, extended load data.
- `PCPlus4W`  out  32  registered `PCPlus4M`.

## Operation
- Word index = `ALUResultM[ADDR_W+1:2]`. Higher address bits are ignored, so addresses wrap modulo `MEM_WORDS*4`. Byte offset is `ALUResultM[1:0]`.
- Stores, when `MemWriteM`=1 and `rst`=0, write on the rising edge with per-byte enables:
  - SB (000): writes byte lane `addr[1:0]` with `WriteDataM[7:0]`.
  - SH (001): writes lanes {addr[1],0} and {addr[1],1} with `WriteDataM[15:0]`; `addr[0]` is ignored.
  - SW (010): writes all four lanes; `addr[1:0]` is ignored.
  - Any other funct3 with `MemWriteM`=1 writes nothing.
- Loads: the word at the index is read and the lane is selected the same way as for stores.
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W passes the word through.
  - Undefined funct3 values (011, 110, 111) return the raw word.
- The extended value is computed every cycle, regardless of `ResultSrcM`, and captured into `ReadDataW`.
- Little-endian: lane 0 is bits [7:0].
- Memory contents are not reset and are undefined until written.
- `rst`=1 suppresses any store presented in that cycle.
- There is no stall or flush input. Every cycle advances the M/W register; bubbles arrive from upstream as `RegWriteM`=0 and `MemWriteM`=0.

## Timing
- Reset: on an edge with `rst`=1, all W outputs become 0. `RegWriteW`=0, `ResultSrcW`=00, `RdW`=0, `ALUResultW`=`ReadDataW`=`PCPlus4W`=0x00000000.
- Latency is one cycle: inputs present in cycle N appear on the W outputs after edge N+1.
- The memory read is synchronous: the read data captured into `ReadDataW` at edge N+1 is the contents from before that edge's write.
  - If a store and a load target the same word in the same cycle, the load returns the old data.
  - A load in cycle N+1 after a store in cycle N sees the new data.
- Write-back therefore sees the load result at the same time as the rest of the instruction's W-stage fields.
- Reset asserted mid-stream discards the in-flight M instruction. The W outputs read zero from the next edge. Memory contents written before reset are retained.

## Test plan
- **Reset:** drive random M inputs with `rst`=1 for 2 cycles, then release. Required: all W outputs are 0 while reset is applied. One edge after release, the W outputs equal the M inputs from the cycle before that edge.
- **Word round-trip:**
  - SW 0xDEADBEEF to address 0x10, then LW from 0x10 with `ResultSrcM`=01, `RdM`=5, `RegWriteM`=1.
  - Required: `ReadDataW`=0xDEADBEEF, `RdW`=5, `RegWriteW`=1, `ResultSrcW`=01.
- **Sub-word access and extension** (after the word store above):
  - SB 0x80 to 0x11 → LW 0x10 = 0xDEAD80EF.
  - LB 0x11 = 0xFFFFFF80; LBU 0x11 = 0x00000080.
  - SH 0x8001 to 0x12 → LH 0x12 = 0xFFFF8001; LHU 0x12 = 0x00008001.
- **Same-cycle read/write and reset-suppressed store:**
  - Word 0x20 holds 0x11111111. Issue SW 0x22222222 to 0x20 while reading 0x20 in the same cycle: `ReadDataW`=0x11111111.
  - Next cycle, LW 0x20: `ReadDataW`=0x22222222.
  - SW 0x33333333 to 0x20 issued with `rst`=1, then LW 0x20 after reset is released: `ReadDataW`=0x22222222.
- **Address wrap and pass-through:**
  - With `MEM_WORDS`=1024, SW 0xA5A5A5A5 to 0x00001004, then LW 0x00000004: `ReadDataW`=0xA5A5A5A5.
  - JAL-type cycle with `PCPlus4M`=0x00000104, `ResultSrcM`=10: `PCPlus4W`=0x00000104 after one edge.
- **Invalid store funct3:** `MemWriteM`=1 with funct3=011 to address 0x30, then LW 0x30: `ReadDataW` still holds the prior contents of word 0x30.
